// File: rtl/mem_responder.sv
`default_nettype none
//==============================================================================
// Module   : mem_responder
// Purpose  : Byte-serial client front end for a 32-bit word memory. A client
//            request is accepted in IDLE; writes collect four bytes (LSB
//            first) and issue one memory write cycle, reads issue a two-cycle
//            memory read and return the word as four bytes (LSB first).
//            Addresses outside 2^ADDR_BITS words keep the full handshake but
//            never touch the memory (reads return zero).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk       in   1   clock, all state changes on the rising edge
//   reset     in   1   asynchronous reset, active low
//   req       in   1   client request, held until the transaction completes
//   wr        in   1   request type (1 = write, 0 = read), valid with req
//   addr      in  32   word address, valid with req
//   wr_data   in   8   write byte stream from the client
//   rd_data   out  8   read byte stream to the client (0 outside RD_TX)
//   resp      out  1   one-cycle marker: byte phase starts next cycle
//   busy      out  1   high in every state except IDLE
//   cs        out  1   memory chip select
//   we        out  1   memory write enable
//   mem_addr  out 32   memory word address
//   mem_bus   inout 32 memory data bus, driven only during a memory write
//==============================================================================
module mem_responder #(
   parameter int ADDR_BITS = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [7:0]  wr_data,
   output logic [7:0]  rd_data,
   output logic        resp,
   output logic        busy,
   output logic        cs,
   output logic        we,
   output logic [31:0] mem_addr,
   inout  wire  [31:0] mem_bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ACK   = 4'd1,
      WR_RX    = 4'd2,
      MEM_WR   = 4'd3,
      MEM_RD   = 4'd4,
      RD_ACK   = 4'd5,
      RD_TX    = 4'd6,
      WAIT_REL = 4'd7
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;        // byte index / memory-read cycle count
   logic [31:0] addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [31:0] word_q, word_d;      // assembled write word or captured read word

   logic        resp_q, resp_d;
   logic        busy_q, busy_d;
   logic        cs_q, cs_d;
   logic        we_q, we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        drive_q, drive_d;

   logic        in_range_d;
   logic        mem_cycle_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      word_d  = word_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = addr;
               wr_d    = wr;
               cnt_d   = 2'd0;
               word_d  = 32'h0;
               state_d = wr ? WR_ACK : MEM_RD;
            end
         end
         WR_ACK: begin
            cnt_d   = 2'd0;
            state_d = WR_RX;
         end
         WR_RX: begin
            word_d[{cnt_q, 3'b000} +: 8] = wr_data;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = MEM_WR;
            end
         end
         MEM_WR: begin
            state_d = WAIT_REL;
         end
         MEM_RD: begin
            cnt_d = cnt_q + 2'd1;
            // The bus is sampled at the end of the second select cycle.
            if (cnt_q == 2'd1) begin
               word_d  = (addr_q[31:ADDR_BITS] == '0) ? mem_bus : 32'h0;
               state_d = RD_ACK;
            end
         end
         RD_ACK: begin
            cnt_d   = 2'd0;
            state_d = RD_TX;
         end
         RD_TX: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered as a function of the state being entered, so
      // they line up with the state itself rather than lagging it by a cycle.
      in_range_d  = (addr_d[31:ADDR_BITS] == '0);
      mem_cycle_d = in_range_d && ((state_d == MEM_WR) || (state_d == MEM_RD));
      resp_d      = (state_d == WR_ACK) || (state_d == RD_ACK);
      busy_d      = (state_d != IDLE);
      cs_d        = mem_cycle_d;
      we_d        = mem_cycle_d && wr_d;
      drive_d     = mem_cycle_d && wr_d;
      mem_addr_d  = mem_cycle_d ? addr_d : 32'h0;
      rd_data_d   = (state_d == RD_TX) ? word_d[{cnt_d, 3'b000} +: 8] : 8'h00;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         addr_q     <= 32'h0;
         wr_q       <= 1'b0;
         word_q     <= 32'h0;
         resp_q     <= 1'b0;
         busy_q     <= 1'b0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         mem_addr_q <= 32'h0;
         rd_data_q  <= 8'h00;
         drive_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         word_q     <= word_d;
         resp_q     <= resp_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         we_q       <= we_d;
         mem_addr_q <= mem_addr_d;
         rd_data_q  <= rd_data_d;
         drive_q    <= drive_d;
      end
   end

   assign resp     = resp_q;
   assign busy     = busy_q;
   assign cs       = cs_q;
   assign we       = we_q;
   assign mem_addr = mem_addr_q;
   assign rd_data  = rd_data_q;

   // word_q holds the assembled write word for the whole MEM_WR cycle.
   assign mem_bus  = drive_q ? word_q : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. A cycle-offset reference
//            model predicts every output on every cycle; directed sequences
//            add literal expectations on top.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [7:0]  wr_data = 8'h00;
   logic [7:0]  rd_data;
   logic        resp, busy, cs, we;
   logic [31:0] mem_addr;
   wire  [31:0] mem_bus;

   logic [31:0] ext_mem [128];   // the memory attached to the DUT
   logic [31:0] ref_mem [128];   // the model's view of memory contents

   int n_cmp = 0;
   int n_bad = 0;

   mem_responder #(.ADDR_BITS(7)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .wr       (wr),
      .addr     (addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .resp     (resp),
      .busy     (busy),
      .cs       (cs),
      .we       (we),
      .mem_addr (mem_addr),
      .mem_bus  (mem_bus)
   );

   always #5 clk = ~clk;

   // Asynchronous-read memory; writes land on the clock edge.
   assign mem_bus = (cs && !we) ? ext_mem[mem_addr[6:0]] : 32'bz;
   always @(posedge clk) begin
      if (cs && we) ext_mem[mem_addr[6:0]] <= mem_bus;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Undriven bus: high-Z in a four-state simulator, zero in a two-state one.
   task automatic chk_bus_idle(input string name);
      n_cmp++;
      if (!($isunknown(mem_bus) || mem_bus == 32'h0)) begin
         n_bad++;
         $display("FAIL %s: got %h, expected high-Z (t=%0t)", name, mem_bus, $time);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return a[31:7] == 25'h0;
   endfunction

   //---------------------------------------------------------------------------
   // Reference model + per-cycle compare. m_n counts cycles since the accepting
   // edge; expected outputs follow directly from the documented latencies.
   //---------------------------------------------------------------------------
   bit          m_busy = 1'b0;
   bit          m_wait = 1'b0;
   int          m_n = 0;
   bit          m_wr = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_word = 32'h0;

   initial begin : model_compare
      bit          e_resp, e_cs, e_drv;
      logic [31:0] e_addr;
      logic [7:0]  e_rd;
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_busy = 1'b0;
         end else if (!m_busy) begin
            if (req) begin
               m_busy = 1'b1; m_wait = 1'b0; m_n = 1;
               m_wr = wr; m_addr = addr; m_word = 32'h0;
            end
         end else if (m_wait) begin
            if (!req) m_busy = 1'b0;
         end else begin
            if (m_wr && m_n >= 2 && m_n <= 5) m_word[8*(m_n-2) +: 8] = wr_data;
            if (m_wr && m_n == 6 && in_rng(m_addr)) ref_mem[m_addr[6:0]] = m_word;
            if (!m_wr && m_n == 2) m_word = in_rng(m_addr) ? ref_mem[m_addr[6:0]] : 32'h0;
            m_n++;
            if (m_n == (m_wr ? 7 : 8)) m_wait = 1'b1;
         end
         #2;
         if (!reset) m_busy = 1'b0;

         e_resp = 1'b0; e_cs = 1'b0; e_drv = 1'b0; e_addr = 32'h0; e_rd = 8'h00;
         if (m_busy && !m_wait) begin
            if (m_wr) begin
               e_resp = (m_n == 1);
               e_cs   = (m_n == 6) && in_rng(m_addr);
               e_drv  = e_cs;
            end else begin
               e_resp = (m_n == 3);
               e_cs   = (m_n <= 2) && in_rng(m_addr);
               if (m_n >= 4 && m_n <= 7) e_rd = m_word[8*(m_n-4) +: 8];
            end
            e_addr = e_cs ? m_addr : 32'h0;
         end
         chk("busy",     32'(busy),    32'(m_busy));
         chk("resp",     32'(resp),    32'(e_resp));
         chk("cs",       32'(cs),      32'(e_cs));
         chk("we",       32'(we),      32'(e_drv));
         chk("mem_addr", mem_addr,     e_addr);
         chk("rd_data",  32'(rd_data), 32'(e_rd));
         if (e_drv) chk("mem_bus_wdata", mem_bus, m_word);
         else if (!(cs && !we)) chk_bus_idle("mem_bus_idle");
      end
   end

   //---------------------------------------------------------------------------
   // Transaction driver with per-cycle observations for directed checks.
   //---------------------------------------------------------------------------
   logic [31:0] got_rd;
   logic [31:0] wr_seen;
   int          resp_cyc, wr_cyc, cs_cnt;
   bit          busy_hist [32];

   // drop: cycle in which req is lowered (1 = right after acceptance).
   task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int drop, input bit scramble, input bit rel);
      int last;
      last = (drop > 8) ? drop : 8;
      got_rd = 32'h0; wr_seen = 32'h0; resp_cyc = -1; wr_cyc = -1; cs_cnt = 0;
      @(negedge clk);
      if (rel) reset = 1'b1;
      req = 1'b1; wr = w; addr = a; wr_data = 8'($urandom);
      for (int c = 1; c <= last + 1; c++) begin
         @(negedge clk);
         busy_hist[c] = busy;
         if (resp && resp_cyc < 0) resp_cyc = c;
         if (cs) cs_cnt++;
         if (cs && we) begin wr_cyc = c; wr_seen = mem_bus; end
         if (c >= 4 && c <= 7) got_rd[8*(c-4) +: 8] = rd_data;
         if (c >= 2 && c <= 5) wr_data = d[8*(c-2) +: 8];
         else wr_data = 8'($urandom);
         if (c == 1 && scramble) begin addr = $urandom; wr = ~w; end
         if (c >= drop) req = 1'b0;
      end
   endtask

   initial begin : stimulus
      int ones;
      for (int i = 0; i < 128; i++) begin
         ext_mem[i] = $urandom;
      end
      ext_mem[0]   = 32'h2008_0005;
      ext_mem[127] = 32'h03E0_0008;
      for (int i = 0; i < 128; i++) ref_mem[i] = ext_mem[i];

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",     32'(busy),    32'h0);
      chk("rst_resp",     32'(resp),    32'h0);
      chk("rst_cs",       32'(cs),      32'h0);
      chk("rst_we",       32'(we),      32'h0);
      chk("rst_mem_addr", mem_addr,     32'h0);
      chk("rst_rd_data",  32'(rd_data), 32'h0);
      chk_bus_idle("rst_mem_bus");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Write then read back word 5
      txn(1'b1, 32'd5, 32'h1234_5678, 6, 1'b0, 1'b0);
      chk("wr5_resp_cycle", 32'(resp_cyc), 32'd1);
      chk("wr5_mem_cycle",  32'(wr_cyc),   32'd6);
      chk("wr5_mem_data",   wr_seen,       32'h1234_5678);
      chk("wr5_model",      ref_mem[5],    32'h1234_5678);
      txn(1'b0, 32'd5, 32'h0, 8, 1'b0, 1'b0);
      chk("rd5_resp_cycle", 32'(resp_cyc), 32'd3);
      chk("rd5_cs_cycles",  32'(cs_cnt),   32'd2);
      chk("rd5_bytes",      got_rd,        32'h1234_5678);

      // Preloaded top word
      txn(1'b0, 32'd127, 32'h0, 8, 1'b0, 1'b0);
      chk("rd127_word", got_rd, 32'h03E0_0008);

      // Out-of-range accesses
      txn(1'b1, 32'h80, 32'hDEAD_BEEF, 7, 1'b1, 1'b0);
      chk("oor_wr_cs", 32'(cs_cnt), 32'd0);
      txn(1'b0, 32'h80, 32'h0, 8, 1'b0, 1'b0);
      chk("oor_rd_cs",   32'(cs_cnt),   32'd0);
      chk("oor_rd_word", got_rd,        32'h0);
      chk("oor_rd_resp", 32'(resp_cyc), 32'd3);
      txn(1'b0, 32'd0, 32'h0, 8, 1'b0, 1'b0);
      chk("rd0_unchanged", got_rd, 32'h2008_0005);

      // req held 10 cycles past the last read byte (cycles 8..17)
      txn(1'b0, 32'd5, 32'h0, 18, 1'b0, 1'b0);
      ones = 0;
      for (int c = 8; c <= 18; c++) ones += int'(busy_hist[c]);
      chk("hold_busy_cycles", 32'(ones),         32'd11);
      chk("hold_single_txn",  32'(cs_cnt),       32'd2);
      chk("hold_release",     32'(busy_hist[19]), 32'd0);

      // Reset in cycle 3 of a write to word 9
      txn(1'b1, 32'd9, 32'hCAFE_F00D, 6, 1'b0, 1'b0);
      chk("wr9_model", ref_mem[9], 32'hCAFE_F00D);
      @(negedge clk); req = 1'b1; wr = 1'b1; addr = 32'd9; wr_data = 8'h00;
      @(negedge clk);
      @(negedge clk); wr_data = 8'h44;
      @(negedge clk); wr_data = 8'h33;
      #1 reset = 1'b0; req = 1'b0;
      #1;
      chk("abort_busy",     32'(busy),    32'h0);
      chk("abort_resp",     32'(resp),    32'h0);
      chk("abort_cs",       32'(cs),      32'h0);
      chk("abort_we",       32'(we),      32'h0);
      chk("abort_mem_addr", mem_addr,     32'h0);
      chk("abort_rd_data",  32'(rd_data), 32'h0);
      chk_bus_idle("abort_mem_bus");
      repeat (3) @(negedge clk);
      // req already high as reset releases: first edge accepts it
      txn(1'b0, 32'd9, 32'h0, 8, 1'b0, 1'b1);
      chk("rd9_after_abort", got_rd,        32'hCAFE_F00D);
      chk("rd9_resp_cycle",  32'(resp_cyc), 32'd3);

      // Random traffic
      for (int i = 0; i < 256; i++) begin
         bit          w;
         logic [31:0] a;
         w = 1'($urandom);
         a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
         txn(w, a, $urandom, $urandom_range(1, 12), 1'($urandom), 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
